// File: rtl/cloud_spawner.sv
// Cloud slot spawner/scroller: spawns clouds at the right edge, scrolls them left per frame.
// Optional CLOUD_PARALLAX_EN: odd-index slots scroll at half speed (far layer).
module cloud_spawner #(
    parameter int unsigned NUM_SLOTS = 3,
    parameter int unsigned SPRITE_W  = 92,
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned Y_MIN     = 40,
    parameter int unsigned Y_RANGE   = 64,
    parameter int unsigned GAP_MIN   = 60,
    parameter int unsigned GAP_MASK  = 63,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     frame_Clk,
    input  logic                     Reset,
    input  logic                     enable,
    input  logic [2:0]               speed,
    output logic [NUM_SLOTS*11-1:0]  pos_x,
    output logic [NUM_SLOTS*10-1:0]  pos_y,
    output logic [NUM_SLOTS-1:0]     slot_valid,
    output logic                     spawn_pulse
);

    localparam int unsigned       GAP_W     = $clog2(GAP_MIN + GAP_MASK + 1);
    localparam logic [10:0]       SPAWN_X   = 11'(SCREEN_W);
    localparam logic signed [11:0] RETIRE_X = -12'(SPRITE_W);
    localparam logic [15:0]       LFSR_TAPS = 16'hB400;

    typedef enum logic {IDLE, ACTIVE} slot_state_t;

    slot_state_t      state_q [NUM_SLOTS];
    slot_state_t      state_d [NUM_SLOTS];
    logic [10:0]      x_q     [NUM_SLOTS];
    logic [10:0]      x_d     [NUM_SLOTS];
    logic [9:0]       y_q     [NUM_SLOTS];
    logic [9:0]       y_d     [NUM_SLOTS];
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_d;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_d;
    logic             pulse_d;

    logic                 spawn_found;
    logic                 spawn_now;
    logic [NUM_SLOTS-1:0] spawn_sel;
    logic [3:0]           step;
    logic signed [11:0]   nx;

    always_ff @(posedge frame_Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= IDLE;
                x_q[i]     <= SPAWN_X;
                y_q[i]     <= 10'(Y_MIN);
            end
            gap_cnt     <= GAP_W'(GAP_MIN);
            lfsr_q      <= LFSR_SEED;
            spawn_pulse <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
            end
            gap_cnt     <= gap_d;
            lfsr_q      <= lfsr_d;
            spawn_pulse <= pulse_d;
        end
    end

    always_comb begin
        lfsr_d      = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & LFSR_TAPS);
        gap_d       = gap_cnt;
        pulse_d     = 1'b0;
        spawn_found = 1'b0;
        spawn_sel   = '0;
        step        = '0;
        nx          = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            state_d[i] = state_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
        end

        // Eligibility looks only at pre-edge state, so a slot retiring this frame waits a frame.
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (state_q[i] == IDLE && !spawn_found) begin
                spawn_found  = 1'b1;
                spawn_sel[i] = 1'b1;
            end
        end
        spawn_now = enable && (gap_cnt == '0) && spawn_found;

        if (enable) begin
            if (gap_cnt != '0) begin
                gap_d = gap_cnt - GAP_W'(1);
            end else if (spawn_found) begin
                gap_d   = GAP_W'(GAP_MIN) + GAP_W'(lfsr_q[13:8] & 6'(GAP_MASK));
                pulse_d = 1'b1;
            end

            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
`ifdef CLOUD_PARALLAX_EN
                step = (i % 2 == 1) ? 4'(({1'b0, speed} + 4'd1) >> 1) : {1'b0, speed};
`else
                step = {1'b0, speed};
`endif
                if (state_q[i] == ACTIVE) begin
                    nx = $signed({x_q[i][10], x_q[i]}) - $signed({8'b0, step});
                    if (nx <= RETIRE_X) begin
                        state_d[i] = IDLE;
                        x_d[i]     = SPAWN_X;
                    end else begin
                        x_d[i] = nx[10:0];
                    end
                end else if (spawn_now && spawn_sel[i]) begin
                    state_d[i] = ACTIVE;
                    x_d[i]     = SPAWN_X;
                    y_d[i]     = 10'(Y_MIN) + {4'b0, lfsr_q[5:0] & 6'(Y_RANGE - 1)};
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
        assign pos_x[11*g +: 11] = x_q[g];
        assign pos_y[10*g +: 10] = y_q[g];
        assign slot_valid[g]     = (state_q[g] == ACTIVE);
    end

endmodule

// File: tb/tb_cloud_spawner.sv
// Directed bench for cloud_spawner with a per-frame reference model of slots, gap and LFSR.
module tb_cloud_spawner;

    logic        frame_clk;
    logic        rst;
    logic        enable;
    logic [2:0]  speed;
    logic [32:0] pos_x;
    logic [29:0] pos_y;
    logic [2:0]  slot_valid;
    logic        spawn_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    int m_x [3];
    int m_y [3];
    int m_v [3];
    int m_gap;
    int m_pulse;
    logic [15:0] m_lfsr;

`ifdef CLOUD_PARALLAX_EN
    localparam int STEP1_AT3 = 2;
`else
    localparam int STEP1_AT3 = 3;
`endif

    cloud_spawner #(
        .NUM_SLOTS(3),
        .SPRITE_W (92),
        .SCREEN_W (640),
        .Y_MIN    (40),
        .Y_RANGE  (64),
        .GAP_MIN  (60),
        .GAP_MASK (63),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .frame_Clk  (frame_clk),
        .Reset      (rst),
        .enable     (enable),
        .speed      (speed),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .slot_valid (slot_valid),
        .spawn_pulse(spawn_pulse)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int x_of(input int i);
        logic signed [10:0] v;
        v = pos_x[11*i +: 11];
        return int'(v);
    endfunction

    function automatic int y_of(input int i);
        return int'(pos_y[10*i +: 10]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_x[i] = 640;
            m_y[i] = 40;
            m_v[i] = 0;
        end
        m_gap   = 60;
        m_pulse = 0;
        m_lfsr  = 16'hACE1;
    endtask

    task automatic model_step();
        int  st;
        int  nxv;
        bit  found;
        int  idx;
        bit  fb;
        found = 0;
        idx   = 0;
        for (int i = 0; i < 3; i++)
            if (m_v[i] == 0 && !found) begin
                found = 1;
                idx   = i;
            end
        m_pulse = 0;
        if (enable) begin
            for (int i = 0; i < 3; i++) begin
                if (m_v[i] == 1) begin
                    st = int'(speed);
`ifdef CLOUD_PARALLAX_EN
                    if (i % 2 == 1) st = (int'(speed) + 1) / 2;
`endif
                    nxv = m_x[i] - st;
                    if (nxv <= -92) begin
                        m_v[i] = 0;
                        m_x[i] = 640;
                    end else begin
                        m_x[i] = nxv;
                    end
                end
            end
            if (m_gap > 0) begin
                m_gap--;
            end else if (found) begin
                m_v[idx] = 1;
                m_x[idx] = 640;
                m_y[idx] = 40 + int'(m_lfsr[5:0]);
                m_gap    = 60 + int'(m_lfsr[13:8]);
                m_pulse  = 1;
            end
        end
        fb     = m_lfsr[0];
        m_lfsr = m_lfsr >> 1;
        if (fb) m_lfsr = m_lfsr ^ 16'hB400;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("x%0d", i), x_of(i), m_x[i]);
            check($sformatf("y%0d", i), y_of(i), m_y[i]);
            check($sformatf("valid%0d", i), slot_valid[i], m_v[i]);
        end
        check("pulse", spawn_pulse, m_pulse);
        check("gap", dut.gap_cnt, m_gap);
    endtask

    task automatic tick();
        @(posedge frame_clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Called just after an edge: asserts Reset between edges and checks outputs immediately.
    task automatic do_reset();
        #3 rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        check("rst_valid", slot_valid, 0);
        check("rst_pulse", spawn_pulse, 0);
        check("rst_x0", x_of(0), 640);
        #3 rst = 1'b0;
    endtask

    int exp_gap;

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        speed  = 3'd2;
        model_reset();
        #2;
        compare_all();
        check("rst_gap", dut.gap_cnt, 60);
        check("rst_y2", y_of(2), 40);
        #10 rst = 1'b0;

        // first spawn lands on frame 61
        repeat (60) tick();
        check("pre_spawn_valid", slot_valid, 0);
        tick();
        check("spawn_valid0", slot_valid[0], 1);
        check("spawn_pulse0", spawn_pulse, 1);
        check("spawn_x0", x_of(0), 640);
        check("spawn_y0_range", (y_of(0) >= 40 && y_of(0) <= 103), 1);

        repeat (10) tick();
        check("x0_after10", x_of(0), 620);
        check("valid0_after10", slot_valid[0], 1);

        // scroll to -88 at speed 4, then retire on -92
        speed = 3'd4;
        repeat (177) tick();
        check("x0_at_m88", x_of(0), -88);
        tick();
        check("retire_valid0", slot_valid[0], 0);
        check("retire_x0", x_of(0), 640);

        // fill all slots with speed 0
        do_reset();
        speed = 3'd0;
        for (int k = 0; k < 600 && slot_valid != 3'b111; k++) tick();
        check("fill_done", slot_valid, 3'b111);
        repeat (130) tick();
        repeat (5) begin
            tick();
            check("full_pulse", spawn_pulse, 0);
            check("full_gap", dut.gap_cnt, 0);
        end

        speed = 3'd7;
        for (int k = 0; k < 200 && slot_valid != 3'b000; k++) tick();
        check("all_retired", slot_valid, 0);
        check("retired_pulse", spawn_pulse, 0);
        tick();
        check("respawn_valid", slot_valid, 3'b001);
        check("respawn_pulse", spawn_pulse, 1);
        check("respawn_x0", x_of(0), 640);

        // freeze with enable=0
        repeat (20) tick();
        check("x0_pre_freeze", x_of(0), 500);
        exp_gap = m_gap;
        enable = 1'b0;
        repeat (20) begin
            tick();
            check("frz_x0", x_of(0), 500);
            check("frz_valid", slot_valid, 3'b001);
            check("frz_pulse", spawn_pulse, 0);
            check("frz_gap", dut.gap_cnt, exp_gap);
        end
        enable = 1'b1;
        for (int k = 0; k < 200 && spawn_pulse != 1'b1; k++) tick();
        check("post_freeze_spawn", spawn_pulse, 1);

        // reset mid-operation, then per-slot step at speed 3
        do_reset();
        speed = 3'd3;
        for (int k = 0; k < 400 && slot_valid[1] != 1'b1; k++) tick();
        check("slot1_spawn", slot_valid[1], 1);
        check("slot1_x", x_of(1), 640);
        tick();
        check("slot1_step", x_of(1), 640 - STEP1_AT3);
        tick();
        check("slot1_step2", x_of(1), 640 - 2 * STEP1_AT3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
